// File: rtl/uart_bridge_pkg.sv
// Shared types and constants for the UART FIFO bridge: TX FSM encoding,
// status-word bit positions and the "no data" read value.
package uart_bridge_pkg;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_SEND = 1'b1
    } tx_state_e;

    localparam int STAT_TX_CNT_LSB  = 0;
    localparam int STAT_RX_CNT_LSB  = 8;
    localparam int STAT_TX_FULL     = 16;
    localparam int STAT_RX_EMPTY    = 17;
    localparam int STAT_TX_BUSY     = 18;
    localparam int STAT_RX_OVERRUN  = 19;

    localparam logic [31:0] EMPTY_WORD = 32'hFFFF_FFFF;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with combinational head; push/pop take effect at the next edge.
// Backpressure: push is ignored while full, pop is ignored while empty.
module sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      din,
    output logic [WIDTH-1:0]      dout,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [WIDTH-1:0]      mem_d [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count_q == (DEPTH_LOG2 + 1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage is cleared on reset so the head (and uart_dat_di) reads zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/uart_fifo_bridge.sv
// CPU <-> simpleuart bridge with TX/RX FIFOs; CPU writes stall only when TX is full, reads never stall.
// Optional UART_FIFO_BRIDGE_RX_OVERRUN_EN: keep polling while RX is full and flag dropped bytes.
module uart_fifo_bridge
    import uart_bridge_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        bus_dat_we,
    input  logic        bus_dat_re,
    input  logic [31:0] bus_dat_di,
    output logic [31:0] bus_dat_do,
    output logic        bus_dat_wait,
    input  logic        bus_stat_we,
    output logic [31:0] bus_stat_do,
    output logic        uart_dat_we,
    output logic [31:0] uart_dat_di,
    input  logic        uart_dat_wait,
    output logic        uart_dat_re,
    input  logic [31:0] uart_dat_do
);

    logic [7:0]          tx_head, rx_head;
    logic [DEPTH_LOG2:0] tx_count, rx_count;
    logic                tx_full, tx_empty, rx_full, rx_empty;
    logic                tx_push, tx_pop, rx_push, rx_pop;
    logic                rx_valid, rx_overrun, tx_busy;
    logic                unused_bits;

    tx_state_e state_q, state_d;
    logic      uart_we_q, uart_we_d;

    sync_fifo #(.WIDTH(8), .DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (tx_push),
        .pop   (tx_pop),
        .din   (bus_dat_di[7:0]),
        .dout  (tx_head),
        .count (tx_count),
        .full  (tx_full),
        .empty (tx_empty)
    );

    sync_fifo #(.WIDTH(8), .DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rx_push),
        .pop   (rx_pop),
        .din   (uart_dat_do[7:0]),
        .dout  (rx_head),
        .count (rx_count),
        .full  (rx_full),
        .empty (rx_empty)
    );

    assign tx_push      = bus_dat_we && !tx_full;
    assign bus_dat_wait = bus_dat_we && tx_full;
    assign tx_pop       = uart_we_q && !uart_dat_wait;
    assign uart_dat_we  = uart_we_q;
    assign uart_dat_di  = {24'd0, tx_head};
    assign tx_busy      = (state_q != TX_IDLE) || !tx_empty;

    assign rx_pop     = bus_dat_re && !rx_empty;
    assign bus_dat_do = rx_empty ? EMPTY_WORD : {24'd0, rx_head};
    assign rx_valid   = (uart_dat_do[31:8] == 24'd0);

    // The strobe is a flop alongside the state so it is high for exactly the SEND cycles.
    always_comb begin
        state_d   = state_q;
        uart_we_d = uart_we_q;
        case (state_q)
            TX_IDLE: begin
                if (!tx_empty) begin
                    state_d   = TX_SEND;
                    uart_we_d = 1'b1;
                end
            end
            TX_SEND: begin
                if (!uart_dat_wait) begin
                    state_d   = TX_IDLE;
                    uart_we_d = 1'b0;
                end
            end
            default: begin
                state_d   = TX_IDLE;
                uart_we_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= TX_IDLE;
            uart_we_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            uart_we_q <= uart_we_d;
        end
    end

`ifdef UART_FIFO_BRIDGE_RX_OVERRUN_EN
    logic rx_overrun_q, rx_overrun_d;

    assign uart_dat_re = 1'b1;
    assign rx_push     = rx_valid && !rx_full;
    assign rx_overrun  = rx_overrun_q;
    assign unused_bits = ^bus_dat_di[31:8];

    // A byte dropped in the same cycle as a clear keeps the flag set.
    always_comb begin
        rx_overrun_d = rx_overrun_q;
        if (rx_valid && rx_full) begin
            rx_overrun_d = 1'b1;
        end else if (bus_stat_we) begin
            rx_overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_overrun_q <= 1'b0;
        end else begin
            rx_overrun_q <= rx_overrun_d;
        end
    end
`else
    assign uart_dat_re = !rx_full;
    assign rx_push     = uart_dat_re && rx_valid;
    assign rx_overrun  = 1'b0;
    assign unused_bits = ^{bus_dat_di[31:8], bus_stat_we};
`endif

    always_comb begin
        bus_stat_do                                   = '0;
        bus_stat_do[STAT_TX_CNT_LSB +: 8]             = 8'(tx_count);
        bus_stat_do[STAT_RX_CNT_LSB +: 8]             = 8'(rx_count);
        bus_stat_do[STAT_TX_FULL]                     = tx_full;
        bus_stat_do[STAT_RX_EMPTY]                    = rx_empty;
        bus_stat_do[STAT_TX_BUSY]                     = tx_busy;
        bus_stat_do[STAT_RX_OVERRUN]                  = rx_overrun;
    end

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Self-checking bench: vector table, directed multi-cycle sequences and
// randomized traffic compared against a queue-based model of the bridge.
module tb_uart_fifo_bridge;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        bus_dat_we, bus_dat_re, bus_stat_we, uart_dat_wait;
    logic [31:0] bus_dat_di, uart_dat_do;
    logic [31:0] bus_dat_do, bus_stat_do, uart_dat_di;
    logic        bus_dat_wait, uart_dat_we, uart_dat_re;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_fifo_bridge #(.DEPTH_LOG2(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .bus_dat_we    (bus_dat_we),
        .bus_dat_re    (bus_dat_re),
        .bus_dat_di    (bus_dat_di),
        .bus_dat_do    (bus_dat_do),
        .bus_dat_wait  (bus_dat_wait),
        .bus_stat_we   (bus_stat_we),
        .bus_stat_do   (bus_stat_do),
        .uart_dat_we   (uart_dat_we),
        .uart_dat_di   (uart_dat_di),
        .uart_dat_wait (uart_dat_wait),
        .uart_dat_re   (uart_dat_re),
        .uart_dat_do   (uart_dat_do)
    );

    // Reference model: byte queues plus "a byte is currently being offered".
    logic [7:0]  m_tx[$];
    logic [7:0]  m_rx[$];
    bit          m_offer;
    bit          m_ovr;

    logic [31:0] obs_do, obs_stat, obs_udi;
    logic        obs_wait, obs_uwe, obs_ure, last_acc;
    logic [7:0]  acc_log[$];
    int          wait_cnt;

    typedef struct {
        logic        we;
        logic [31:0] di;
        logic        re;
        logic        uwait;
        logic [31:0] udo;
        logic [31:0] exp_do;
        logic [31:0] exp_stat;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_stat();
        logic [31:0] s;
        s        = '0;
        s[7:0]   = 8'(m_tx.size());
        s[15:8]  = 8'(m_rx.size());
        s[16]    = (m_tx.size() == DEPTH);
        s[17]    = (m_rx.size() == 0);
        s[18]    = m_offer || (m_tx.size() != 0);
        s[19]    = m_ovr;
        return s;
    endfunction

    task automatic model_reset();
        m_tx.delete();
        m_rx.delete();
        m_offer = 1'b0;
        m_ovr   = 1'b0;
    endtask

    // One clock cycle: inputs already applied; compare at negedge, update model at posedge.
    task automatic tick();
        logic [31:0] exp_do;
        bit          tx_full_s, rx_full_s, tx_had, valid, ure;
        @(negedge clk);
        obs_do   = bus_dat_do;
        obs_stat = bus_stat_do;
        obs_udi  = uart_dat_di;
        obs_wait = bus_dat_wait;
        obs_uwe  = uart_dat_we;
        obs_ure  = uart_dat_re;
        last_acc = uart_dat_we && !uart_dat_wait;
        if (last_acc) acc_log.push_back(uart_dat_di[7:0]);
        if (bus_dat_wait) wait_cnt++;

        tx_full_s = (m_tx.size() == DEPTH);
        rx_full_s = (m_rx.size() == DEPTH);
        tx_had    = (m_tx.size() != 0);
        exp_do    = (m_rx.size() != 0) ? {24'd0, m_rx[0]} : 32'hFFFF_FFFF;
`ifdef UART_FIFO_BRIDGE_RX_OVERRUN_EN
        ure = 1'b1;
`else
        ure = !rx_full_s;
`endif
        chk("bus_dat_do", bus_dat_do, exp_do);
        chk("bus_dat_wait", 32'(bus_dat_wait), 32'(bus_dat_we && tx_full_s));
        chk("uart_dat_we", 32'(uart_dat_we), 32'(m_offer));
        chk("uart_dat_re", 32'(uart_dat_re), 32'(ure));
        chk("bus_stat_do", bus_stat_do, exp_stat());
        if (m_offer) chk("uart_dat_di", uart_dat_di, {24'd0, m_tx[0]});

        @(posedge clk);
        valid = (uart_dat_do[31:8] == 24'd0);
        if (m_offer && !uart_dat_wait) begin
            void'(m_tx.pop_front());
            m_offer = 1'b0;
        end else if (!m_offer && tx_had) begin
            m_offer = 1'b1;
        end
        if (bus_dat_we && !tx_full_s) m_tx.push_back(bus_dat_di[7:0]);
        if (bus_dat_re && m_rx.size() != 0) void'(m_rx.pop_front());
        if (ure && valid && !rx_full_s) m_rx.push_back(uart_dat_do[7:0]);
`ifdef UART_FIFO_BRIDGE_RX_OVERRUN_EN
        if (valid && rx_full_s) m_ovr = 1'b1;
        else if (bus_stat_we) m_ovr = 1'b0;
`endif
        #1;
    endtask

    task automatic idle_inputs();
        bus_dat_we    = 1'b0;
        bus_dat_re    = 1'b0;
        bus_dat_di    = 32'd0;
        bus_stat_we   = 1'b0;
        uart_dat_wait = 1'b1;
        uart_dat_do   = 32'hFFFF_FFFF;
    endtask

    initial begin
        int  busy;
        int  w17;
        int  n;
        bit  pushed;

        // RX: 0x55 then nothing, reads, invalid word, same-cycle pop+push; then one TX byte.
        vecs[0]  = '{1'b0, 32'h0,   1'b0, 1'b1, 32'h0000_0055, 32'hFFFF_FFFF, 32'h0002_0000};
        vecs[1]  = '{1'b0, 32'h0,   1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0055, 32'h0000_0100};
        vecs[2]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0055, 32'h0000_0100};
        vecs[3]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0002_0000};
        vecs[4]  = '{1'b0, 32'h0,   1'b0, 1'b1, 32'h0000_0100, 32'hFFFF_FFFF, 32'h0002_0000};
        vecs[5]  = '{1'b0, 32'h0,   1'b0, 1'b1, 32'h0000_0011, 32'hFFFF_FFFF, 32'h0002_0000};
        vecs[6]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h0000_0022, 32'h0000_0011, 32'h0000_0100};
        vecs[7]  = '{1'b0, 32'h0,   1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0022, 32'h0000_0100};
        vecs[8]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0022, 32'h0000_0100};
        vecs[9]  = '{1'b0, 32'h0,   1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0002_0000};
        vecs[10] = '{1'b1, 32'h1A3, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0002_0000};
        vecs[11] = '{1'b0, 32'h0,   1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0006_0001};
        vecs[12] = '{1'b0, 32'h0,   1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0006_0001};
        vecs[13] = '{1'b0, 32'h0,   1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0006_0001};
        vecs[14] = '{1'b0, 32'h0,   1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0002_0000};

        idle_inputs();
        reset = 1'b1;
        model_reset();
        #1;
        chk("rst_uart_we", 32'(uart_dat_we), 32'd0);
        chk("rst_uart_re", 32'(uart_dat_re), 32'd1);
        chk("rst_bus_do", bus_dat_do, 32'hFFFF_FFFF);
        chk("rst_uart_di", uart_dat_di, 32'd0);
        chk("rst_stat", bus_stat_do, 32'h0002_0000);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 15; i++) begin
            bus_dat_we    = vecs[i].we;
            bus_dat_di    = vecs[i].di;
            bus_dat_re    = vecs[i].re;
            uart_dat_wait = vecs[i].uwait;
            uart_dat_do   = vecs[i].udo;
            tick();
            chk("vec_do", obs_do, vecs[i].exp_do);
            chk("vec_stat", obs_stat, vecs[i].exp_stat);
        end
        idle_inputs();

        // Three back-to-back writes against a UART that is busy 10 cycles per byte.
        acc_log.delete();
        wait_cnt = 0;
        busy     = 0;
        for (int k = 0; k < 83; k++) begin
            bus_dat_we    = (k < 3);
            bus_dat_di    = 32'h41 + k;
            uart_dat_wait = (busy != 0);
            tick();
            if (last_acc) busy = 10;
            else if (busy > 0) busy--;
        end
        chk("t1_waits", 32'(wait_cnt), 32'd0);
        chk("t1_nacc", 32'(acc_log.size()), 32'd3);
        if (acc_log.size() == 3) begin
            for (int k = 0; k < 3; k++) chk("t1_order", 32'(acc_log[k]), 32'h41 + k);
        end
        chk("t1_txcnt", 32'(obs_stat[7:0]), 32'd0);

        // 17 writes while the UART is stalled; one accept releases the 17th.
        uart_dat_wait = 1'b1;
        w17 = 0;
        for (int k = 0; k < 17; k++) begin
            bus_dat_we = 1'b1;
            bus_dat_di = 32'h60 + k;
            n = 0;
            do begin
                if (k == 16) uart_dat_wait = (n != 3);
                pushed = (m_tx.size() < DEPTH);
                tick();
                if (k == 16 && n == 0) chk("t2_full", 32'(obs_stat[16]), 32'd1);
                if (k == 16 && obs_wait) w17++;
                n++;
            end while (!pushed && n < 20);
        end
        bus_dat_we = 1'b0;
        tick();
        chk("t2_w17", 32'(w17), 32'd4);
        chk("t2_cnt", 32'(obs_stat[7:0]), 32'd16);
        uart_dat_wait = 1'b0;
        repeat (60) tick();
        chk("t2_drain", 32'(obs_stat[7:0]), 32'd0);

        // Fill RX to depth, then offer one more byte.
        uart_dat_wait = 1'b1;
        for (int k = 0; k < 16; k++) begin
            uart_dat_do = 32'h80 + k;
            tick();
        end
        uart_dat_do = 32'h99;
        tick();
`ifdef UART_FIFO_BRIDGE_RX_OVERRUN_EN
        chk("t3_ure_full", 32'(obs_ure), 32'd1);
`else
        chk("t3_ure_full", 32'(obs_ure), 32'd0);
`endif
        chk("t3_rxcnt", 32'(obs_stat[15:8]), 32'd16);
        uart_dat_do = 32'hFFFF_FFFF;
        tick();
`ifdef UART_FIFO_BRIDGE_RX_OVERRUN_EN
        chk("t3_ovr", 32'(obs_stat[19]), 32'd1);
`else
        chk("t3_ovr", 32'(obs_stat[19]), 32'd0);
`endif
        bus_stat_we = 1'b1;
        tick();
        bus_stat_we = 1'b0;
        tick();
        chk("t3_ovr_clr", 32'(obs_stat[19]), 32'd0);
        for (int k = 0; k < 16; k++) begin
            bus_dat_re = 1'b1;
            tick();
            chk("t3_data", obs_do, 32'h80 + k);
        end
        bus_dat_re = 1'b0;
        tick();
        chk("t3_empty", 32'(obs_stat[17]), 32'd1);
        chk("t3_do_empty", obs_do, 32'hFFFF_FFFF);

        // Reset asserted mid-cycle while a byte is being offered.
        for (int k = 0; k < 5; k++) begin
            bus_dat_we = 1'b1;
            bus_dat_di = 32'hC0 + k;
            tick();
        end
        bus_dat_we = 1'b0;
        n = 0;
        while (!m_offer && n < 10) begin
            tick();
            n++;
        end
        @(negedge clk);
        chk("t4_pre_we", 32'(uart_dat_we), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("t4_rst_we", 32'(uart_dat_we), 32'd0);
        chk("t4_rst_do", bus_dat_do, 32'hFFFF_FFFF);
        chk("t4_rst_di", uart_dat_di, 32'd0);
        chk("t4_rst_stat", bus_stat_do, 32'h0002_0000);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        uart_dat_wait = 1'b0;
        repeat (3) tick();
        chk("t4_post_stat", obs_stat, 32'h0002_0000);

        // Randomized traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            if (!(bus_dat_we && obs_wait)) begin
                bus_dat_we = ($urandom_range(0, (k % 1000 < 500) ? 1 : 3) == 0);
                bus_dat_di = $urandom;
            end
            bus_dat_re    = ($urandom_range(0, (k < 1500) ? 7 : 2) == 0);
            uart_dat_wait = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 3))
                0:       uart_dat_do = 32'hFFFF_FFFF;
                1:       uart_dat_do = $urandom | 32'h0000_0100;
                default: uart_dat_do = {24'd0, 8'($urandom)};
            endcase
            bus_stat_we = ($urandom_range(0, 15) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
